// File: rtl/pg_masked_serial_adder_if.sv
// Operand/result bundle for the bit-serial masked adder. The slave modport is
// the adder side, the master modport is the share-generation/consumer side.
interface pg_masked_serial_adder_if #(
  parameter int WIDTH = 8
);
  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; valid must not wait on ready, and ready never depends on valid.
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a0;
  logic [WIDTH-1:0] i_a1;
  logic [WIDTH-1:0] i_b0;
  logic [WIDTH-1:0] i_b1;
  logic [1:0]       i_rnd;
  logic             o_rnd_req;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_s0;
  logic [WIDTH-1:0] o_s1;
  logic             o_c0;
  logic             o_c1;

  modport slave (
    input  i_valid, i_a0, i_a1, i_b0, i_b1, i_rnd, i_ready,
    output o_ready, o_rnd_req, o_valid, o_s0, o_s1, o_c0, o_c1
  );

  modport master (
    output i_valid, i_a0, i_a1, i_b0, i_b1, i_rnd, i_ready,
    input  o_ready, o_rnd_req, o_valid, o_s0, o_s1, o_c0, o_c1
  );
endinterface

// File: rtl/pg_masked_serial_adder.sv
// First-order masked bit-serial ripple-carry adder: one propagate/generate cell,
// a registered DOM AND for the carry, two cycles (PH0/PH1) per bit position.
module pg_masked_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  pg_masked_serial_adder_if.slave bus,
  output logic [1:0] dbg_state
);
  localparam int KW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH0  = 2'd1,
    PH1  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a0_sr, a1_sr, b0_sr, b1_sr;
  logic [WIDTH-1:0] s0_q, s1_q;
  logic [KW-1:0]    k_q;
  logic             c0_q, c1_q;
  logic             p0_q, p1_q, g0_q, g1_q;
  logic             in0_q, in1_q, cr0_q, cr1_q;

  logic last_bit;
  logic p0, p1, g0, g1;
  logic r0, z;

  assign last_bit = (k_q == KW'(WIDTH - 1));
  assign r0       = bus.i_rnd[0];
  assign z        = bus.i_rnd[1];

  // pg_masked cell: p is linear per share; g is a masked AND refreshed by r0.
  always_comb begin
    p0 = a0_sr[0] ^ b0_sr[0];
    p1 = a1_sr[0] ^ b1_sr[0];
    g0 = (a0_sr[0] & b0_sr[0]) ^ ((a0_sr[0] & b1_sr[0]) ^ r0);
    g1 = (a1_sr[0] & b1_sr[0]) ^ ((a1_sr[0] & b0_sr[0]) ^ r0);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_valid) state_d = PH0;
      PH0:     state_d = PH1;
      PH1:     state_d = last_bit ? DONE : PH0;
      DONE:    if (bus.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_ready   = (state_q == IDLE);
  assign bus.o_rnd_req = (state_q == PH0);
  assign bus.o_valid   = (state_q == DONE);
  assign bus.o_s0      = s0_q;
  assign bus.o_s1      = s1_q;
  assign bus.o_c0      = c0_q;
  assign bus.o_c1      = c1_q;
  assign dbg_state     = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a0_sr <= '0;
      a1_sr <= '0;
      b0_sr <= '0;
      b1_sr <= '0;
      s0_q  <= '0;
      s1_q  <= '0;
      k_q   <= '0;
      c0_q  <= 1'b0;
      c1_q  <= 1'b0;
      p0_q  <= 1'b0;
      p1_q  <= 1'b0;
      g0_q  <= 1'b0;
      g1_q  <= 1'b0;
      in0_q <= 1'b0;
      in1_q <= 1'b0;
      cr0_q <= 1'b0;
      cr1_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            a0_sr <= bus.i_a0;
            a1_sr <= bus.i_a1;
            b0_sr <= bus.i_b0;
            b1_sr <= bus.i_b1;
            c0_q  <= 1'b0;
            c1_q  <= 1'b0;
            k_q   <= '0;
          end
        end
        PH0: begin
          p0_q  <= p0;
          p1_q  <= p1;
          g0_q  <= g0;
          g1_q  <= g1;
          in0_q <= p0 & c0_q;
          in1_q <= p1 & c1_q;
          // Cross-domain products are refreshed by z and registered here so
          // they never meet the other domain's terms combinationally.
          cr0_q <= (p0 & c1_q) ^ z;
          cr1_q <= (p1 & c0_q) ^ z;
        end
        PH1: begin
          s0_q[k_q] <= p0_q ^ c0_q;
          s1_q[k_q] <= p1_q ^ c1_q;
          c0_q      <= g0_q ^ in0_q ^ cr0_q;
          c1_q      <= g1_q ^ in1_q ^ cr1_q;
          a0_sr     <= a0_sr >> 1;
          a1_sr     <= a1_sr >> 1;
          b0_sr     <= b0_sr >> 1;
          b1_sr     <= b1_sr >> 1;
          k_q       <= k_q + KW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
